// File: rtl/mem_bus_arbiter.sv
// Two-port round-robin arbiter sequencing fixed-latency reads/writes onto one memory port.
// Optional ARB_LOCK_EN adds lock0/lock1 so an owner can hold the bus across back-to-back accesses.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 8,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              done0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              done1,
`ifdef ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [DATA_W-1:0] rdata,
  output logic              READ,
  output logic              WRITE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  output logic              DOUT_EN,
  input  logic [DATA_W-1:0] mem_data_in
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } port_req_t;

  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);

  state_t          state;
  port_req_t [1:0] preq;
  logic [3:0]      cnt;
  logic            owner, last_owner, sel;
`ifdef ARB_LOCK_EN
  logic            lock_r;
`endif

  assign preq[0] = '{req: req0, we: we0, addr: addr0, wdata: wdata0};
  assign preq[1] = '{req: req1, we: we1, addr: addr1, wdata: wdata1};

  // On a tie the port that did not own the bus last wins.
  always_comb begin
    sel = preq[0].req ? (preq[1].req & ~last_owner) : 1'b1;
`ifdef ARB_LOCK_EN
    if (lock_r && preq[owner].req) sel = owner;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      owner        <= 1'b0;
      last_owner   <= 1'b1;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      done0        <= 1'b0;
      done1        <= 1'b0;
      rdata        <= '0;
      READ         <= 1'b0;
      WRITE        <= 1'b0;
      DOUT_EN      <= 1'b0;
      MEM_ADDR     <= '0;
      MEM_DATA_OUT <= '0;
`ifdef ARB_LOCK_EN
      lock_r       <= 1'b0;
`endif
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      case (state)
        IDLE: begin
          gnt0 <= 1'b0;
          gnt1 <= 1'b0;
`ifdef ARB_LOCK_EN
          lock_r <= lock_r & preq[owner].req;
`endif
          if (req0 || req1) begin
            owner        <= sel;
            gnt0         <= ~sel;
            gnt1         <= sel;
            MEM_ADDR     <= preq[sel].addr;
            MEM_DATA_OUT <= preq[sel].wdata;
            READ         <= ~preq[sel].we;
            WRITE        <= preq[sel].we;
            DOUT_EN      <= preq[sel].we;
            cnt          <= '0;
            state        <= ACCESS;
          end
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (cnt == LAST) begin
            if (READ) rdata <= mem_data_in;
            READ    <= 1'b0;
            WRITE   <= 1'b0;
            DOUT_EN <= 1'b0;
            done0   <= ~owner;
            done1   <= owner;
            state   <= RESP;
          end
        end
        RESP: begin
          gnt0  <= 1'b0;
          gnt1  <= 1'b0;
          state <= IDLE;
`ifdef ARB_LOCK_EN
          lock_r <= owner ? lock1 : lock0;
          if (!(owner ? lock1 : lock0)) last_owner <= owner;
`else
          last_owner <= owner;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter (MEM_LAT=2): a cycle vector table plus hand sequences
// for contention, reset mid-access and (with ARB_LOCK_EN) locked arbitration.
module tb_mem_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0] addr0 = '0, addr1 = '0;
  logic [7:0] wdata0 = '0, wdata1 = '0, mem_data_in = '0;
  logic       gnt0, done0, gnt1, done1, READ, WRITE, DOUT_EN;
  logic [4:0] MEM_ADDR;
  logic [7:0] MEM_DATA_OUT, rdata;
`ifdef ARB_LOCK_EN
  logic       lock0 = 1'b0, lock1 = 1'b0;
`endif

  int total = 0;
  int passed = 0;

  mem_bus_arbiter #(.ADDR_W(5), .DATA_W(8), .MEM_LAT(2)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
`ifdef ARB_LOCK_EN
    .lock0(lock0), .lock1(lock1),
`endif
    .rdata(rdata), .READ(READ), .WRITE(WRITE), .MEM_ADDR(MEM_ADDR),
    .MEM_DATA_OUT(MEM_DATA_OUT), .DOUT_EN(DOUT_EN), .mem_data_in(mem_data_in)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, r0, w0; logic [4:0] a0; logic [7:0] d0;
    logic       r1, w1;      logic [4:0] a1; logic [7:0] d1;
    logic [7:0] mdi;
  } vin_t;

  typedef struct packed {
    logic g0, g1, n0, n1, rd, wr, de;
    logic [4:0] ma; logic [7:0] mo, rdt;
  } vout_t;

  typedef struct packed { vin_t i; vout_t o; } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, r0, w0, input logic [4:0] a0, input logic [7:0] d0,
                     input logic r1, w1, input logic [4:0] a1, input logic [7:0] d1,
                     input logic [7:0] mdi,
                     input logic g0, g1, n0, n1, rd, wr, de,
                     input logic [4:0] ma, input logic [7:0] mo, rdt);
    vec_t v;
    v.i = '{rst, r0, w0, a0, d0, r1, w1, a1, d1, mdi};
    v.o = '{g0, g1, n0, n1, rd, wr, de, ma, mo, rdt};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vout_t snap();
    vout_t s;
    s = '{gnt0, gnt1, done0, done1, READ, WRITE, DOUT_EN, MEM_ADDR, MEM_DATA_OUT, rdata};
    return s;
  endfunction

  // {gnt0,gnt1,done0,done1}
  function automatic logic [3:0] hs();
    return {gnt0, gnt1, done0, done1};
  endfunction

  initial begin
    logic [3:0] exp_hs;
    logic       own;
    //  rst r0 w0 a0     d0     r1 w1 a1     d1     mdi    g0 g1 n0 n1 rd wr de ma     mo     rdt
    add(0,  0, 0, 5'h00, 8'h00, 0, 0, 5'h00, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 5'h00, 8'h00, 8'h00);
    add(1,  1, 0, 5'h03, 8'h11, 0, 0, 5'h00, 8'h00, 8'hA5, 1, 0, 0, 0, 1, 0, 0, 5'h03, 8'h11, 8'h00);
    add(1,  0, 0, 5'h03, 8'h11, 0, 0, 5'h00, 8'h00, 8'hA5, 1, 0, 0, 0, 1, 0, 0, 5'h03, 8'h11, 8'h00);
    add(1,  0, 0, 5'h03, 8'h11, 0, 0, 5'h00, 8'h00, 8'hA5, 1, 0, 1, 0, 0, 0, 0, 5'h03, 8'h11, 8'hA5);
    add(1,  0, 0, 5'h03, 8'h11, 0, 0, 5'h00, 8'h00, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 5'h03, 8'h11, 8'hA5);
    add(1,  0, 0, 5'h00, 8'h11, 1, 1, 5'h1F, 8'h5C, 8'h00, 0, 1, 0, 0, 0, 1, 1, 5'h1F, 8'h5C, 8'hA5);
    add(1,  0, 0, 5'h00, 8'h11, 0, 1, 5'h1F, 8'h5C, 8'hFF, 0, 1, 0, 0, 0, 1, 1, 5'h1F, 8'h5C, 8'hA5);
    add(1,  0, 0, 5'h00, 8'h11, 0, 1, 5'h1F, 8'h5C, 8'hFF, 0, 1, 0, 1, 0, 0, 0, 5'h1F, 8'h5C, 8'hA5);
    add(1,  0, 0, 5'h00, 8'h11, 0, 0, 5'h00, 8'h00, 8'hFF, 0, 0, 0, 0, 0, 0, 0, 5'h1F, 8'h5C, 8'hA5);
    add(1,  1, 0, 5'h04, 8'h11, 0, 0, 5'h00, 8'h00, 8'h3C, 1, 0, 0, 0, 1, 0, 0, 5'h04, 8'h11, 8'hA5);
    add(1,  0, 1, 5'h08, 8'h22, 0, 0, 5'h00, 8'h00, 8'h3C, 1, 0, 0, 0, 1, 0, 0, 5'h04, 8'h11, 8'hA5);
    add(1,  0, 1, 5'h08, 8'h22, 0, 0, 5'h00, 8'h00, 8'h3C, 1, 0, 1, 0, 0, 0, 0, 5'h04, 8'h11, 8'h3C);
    add(1,  0, 1, 5'h08, 8'h22, 0, 0, 5'h00, 8'h00, 8'h3C, 0, 0, 0, 0, 0, 0, 0, 5'h04, 8'h11, 8'h3C);

    #2;
    foreach (vecs[k]) begin
      {reset, req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_data_in} = vecs[k].i;
      step();
      chk($sformatf("vec%0d", k), 32'(snap()), 32'(vecs[k].o));
    end

    // Both requesters held from reset: grants alternate 0,1,0,1, done every 4 cycles.
    reset = 1'b0; req0 = 1'b1; we0 = 1'b0; addr0 = 5'h02; wdata0 = 8'h11;
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'h1E; wdata1 = 8'h77; mem_data_in = 8'h99;
    step();
    chk("contention_reset", 32'(snap()), 32'h0);
    reset = 1'b1;
    for (int t = 0; t < 4; t++) begin
      own = t[0];
      for (int p = 0; p < 4; p++) begin
        step();
        case (p)
          0, 1: exp_hs = own ? 4'b0100 : 4'b1000;
          2:    exp_hs = own ? 4'b0101 : 4'b1010;
          default: exp_hs = 4'b0000;
        endcase
        chk($sformatf("contend_t%0d_p%0d", t, p), 32'(hs()), 32'(exp_hs));
        if (p == 0) chk($sformatf("contend_addr_t%0d", t), 32'(MEM_ADDR), own ? 32'h1E : 32'h02);
      end
    end

    // Port 0 alone so last_owner=0, then abort a port 1 read by reset.
    req1 = 1'b0;
    step(); step(); req0 = 1'b0; step(); step();
    req1 = 1'b1; we1 = 1'b0;
    step();
    chk("abort_grant", 32'(hs()), 32'b0100);
    step();
    chk("abort_2nd_access", 32'({READ, gnt1}), 32'b11);
    reset = 1'b0;
    step();
    chk("abort_cleared", 32'(snap()), 32'h0);
    reset = 1'b1; req0 = 1'b1;
    step();
    chk("abort_tie_port0", 32'(hs()), 32'b1000);
    step(); step();
    chk("abort_then_done0", 32'(hs()), 32'b1010);
    req0 = 1'b0; req1 = 1'b0;
    step();

`ifdef ARB_LOCK_EN
    // lock1 keeps port 1 on the bus for 3 grants; releasing it hands the next grant to port 0.
    reset = 1'b0; step(); reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; lock1 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      own = (t >= 1 && t <= 3);
      if (t == 3) lock1 = 1'b0;
      step();
      chk($sformatf("lock_grant_t%0d", t), 32'({gnt0, gnt1}), own ? 32'b01 : 32'b10);
      step(); step(); step();
    end
    req0 = 1'b0; req1 = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Mutual exclusion of grants and completions, sampled away from the clock edge.
  always @(negedge clk) begin
    if (reset) begin
      if (gnt0 && gnt1) begin
        total++;
        $display("FAIL gnt_exclusive actual=11 required=not both");
      end
      if (done0 && done1) begin
        total++;
        $display("FAIL done_exclusive actual=11 required=not both");
      end
    end
  end
endmodule
